decode_stage: RTL
=================

# decode_stage

Registered, handshaked instruction-decode stage for the 18-bit ISA, parametrised in data width and register-file size. It accepts one instruction per cycle from fetch and presents a registered control/immediate bundle to the register file and ALU. LOAD and STOR are sequenced internally as two output beats. It sits between the fetch unit and the register-file/ALU datapath.

## Interface
- `DATA_W`, 16: datapath and immediate width (≥16).
- `REG_AW`, 4: register-address width; `inst` register fields are zero-extended or truncated to it.
- `INST_W`, 18: instruction width (fixed encoding; ≥18).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous assert, active-low reset.
- `flush` in 1: synchronous pipeline kill.
- `in_valid` in 1 / `in_ready` out 1: instruction handshake.
- `inst` in INST_W: instruction word.
- `out_valid` out 1 / `out_ready` in 1: decoded-bundle handshake.
- `op` out 8: ALU opcode {class[3:0], sub[3:0]}.
- `imm` out DATA_W: extended immediate.
- `sel_imm`, `sel_result`, `mem_we`, `reg_we`, `is_branch` out 1 each.
- `br_cond` out 4: `inst[3:0]` for JCOND.
- `rd_a`, `rd_b`, `ld_reg` out REG_AW: register addresses.
- `busy` out 1: high in MEM0.

## Operation
- States: EMPTY (`out_valid`=0), ONE (single or last beat valid), MEM0 (first of two beats valid).
- `in_ready` = !flush & (EMPTY | (ONE & out_ready)).
- Accept (`in_valid & in_ready`): decode into output register; a LOAD/STOR also loads a second-beat shadow register and enters MEM0, otherwise enters ONE.
- MEM0 & out_ready -> ONE with shadow beat. ONE & out_ready & no accept -> EMPTY.
- `flush` takes priority over all transitions: next state EMPTY, shadow discarded, no accept.
- R-type (class 0000): ADD 0101, ADDU 0110, ADDC 0111, ADDCU 0100, SUB 1001, CMP 1011, AND 0001, OR 0010, XOR 0011, NOT 1111, MOV 1101 (rd_a=`inst[3:0]`). Op = {0000, sub}. AND emits 8'h01.
- Immediate classes 0101/1001/1011/0111 sign-extend `inst[7]`. Classes 0110/1010/1110/1101 zero-extend. LUI 1111 places `inst[7:0]` at imm[DATA_W-1:DATA_W-8] with zeros below. sel_imm=1; op={class, inst[7:4]}.
- Shift class 1000: LSH 0100, RSH 1100, ALSH 0101, ARSH 1101 use registers. LSHI 0000 and RSHI 0001 use imm = zero-extended `inst[3:0]`.
- `reg_we`=1 for all ALU ops except CMP, CMPI, CMPUI, branches, STOR and NOPs.
- LOAD (0100/0000): beat0 op=8'h02, rd_a=rd_b=`inst[3:0]`, reg_we=0. Beat1 is the same with sel_result=1, reg_we=1, ld_reg=`inst[11:8]`.
- STOR (0100/0100): beat0 mem_we=1, rd_a=`inst[11:8]`, rd_b=`inst[3:0]`. Beat1 is a NOP.
- JCOND (0100/1100): is_branch=1, br_cond=`inst[3:0]`, rd_a=`inst[11:8]`, op=8'h02.
- NOP/illegal: op=8'h02, all strobes 0, rd_a=rd_b=ld_reg=`inst[11:8]`.

## Timing
- Reset values: state EMPTY; every output 0 except `in_ready`, which is 1.
- Latency: accept at edge N gives `out_valid` after edge N.
- Throughput: 1/cycle for non-memory instructions with out_ready held high. LOAD/STOR take 2 cycles.
- Outputs hold stable while out_valid & !out_ready.
- Reset asserted mid-MEM0 returns to EMPTY immediately and drops the shadow beat.

## Configuration
- `DECODE_LI_EN` defined: `inst[17:16]`=11 decodes as 16-bit load-immediate. imm=`inst[15:0]` zero-extended, op={1111, `inst[7:4]`}, sel_imm=1, reg_we=1, ld_reg=`inst[11:8]`.
- Undefined: any `inst[17:16]`≠00 decodes as NOP.

## Structure
- `isa_pkg` holds the class/sub-op localparams, the NOP op constant 8'h02, and the state enum.
- Sub-module `imm_extend` (combinational): produces DATA_W imm from {class, sub, inst[7:0]}.
- decode_stage contains the FSM, output register and shadow register.

## Test plan
- ADD r3,r5: 18'h00355 -> next cycle op=8'h05, rd_a=3, rd_b=5, ld_reg=3, reg_we=1, sel_imm=0.
- ADDI r2,#-3: 18'h052FD -> imm=16'hFFFD, sel_imm=1. LUI r1,#12: 18'h0F112 -> imm=16'h1200.
- LOAD r4,[r7]: 18'h04407 with out_ready=1 -> beat0 sel_result=0, reg_we=0. Beat1 sel_result=1, reg_we=1, ld_reg=4. in_ready=0 during MEM0.
- Back-to-back ADDs with out_ready low 3 cycles -> outputs frozen, no instruction lost or duplicated.
- flush during MEM0 with in_valid=1 -> out_valid=0 next cycle, no accept, STOR beat1 never appears.
- 18'h3ABCD -> with `DECODE_LI_EN`: imm=16'hABCD, ld_reg=11. Without it: op=8'h02, reg_we=0.

Source files
------------

// File: rtl/isa_pkg.sv
// Shared ISA constants for the 18-bit decode stage:
// class/sub-op codes, NOP opcode, stage states.
package isa_pkg;

  localparam logic [3:0] CL_R     = 4'b0000;
  localparam logic [3:0] CL_MEM   = 4'b0100;
  localparam logic [3:0] CL_ADDI  = 4'b0101;
  localparam logic [3:0] CL_ADDUI = 4'b0110;
  localparam logic [3:0] CL_ADDCI = 4'b0111;
  localparam logic [3:0] CL_SH    = 4'b1000;
  localparam logic [3:0] CL_SUBI  = 4'b1001;
  localparam logic [3:0] CL_SUBCI = 4'b1010;
  localparam logic [3:0] CL_CMPI  = 4'b1011;
  localparam logic [3:0] CL_MOVI  = 4'b1101;
  localparam logic [3:0] CL_CMPUI = 4'b1110;
  localparam logic [3:0] CL_LUI   = 4'b1111;

  localparam logic [3:0] R_AND   = 4'b0001;
  localparam logic [3:0] R_OR    = 4'b0010;
  localparam logic [3:0] R_XOR   = 4'b0011;
  localparam logic [3:0] R_ADDCU = 4'b0100;
  localparam logic [3:0] R_ADD   = 4'b0101;
  localparam logic [3:0] R_ADDU  = 4'b0110;
  localparam logic [3:0] R_ADDC  = 4'b0111;
  localparam logic [3:0] R_SUB   = 4'b1001;
  localparam logic [3:0] R_CMP   = 4'b1011;
  localparam logic [3:0] R_MOV   = 4'b1101;
  localparam logic [3:0] R_NOT   = 4'b1111;

  localparam logic [3:0] SH_LSHI = 4'b0000;
  localparam logic [3:0] SH_RSHI = 4'b0001;
  localparam logic [3:0] SH_LSH  = 4'b0100;
  localparam logic [3:0] SH_ALSH = 4'b0101;
  localparam logic [3:0] SH_RSH  = 4'b1100;
  localparam logic [3:0] SH_ARSH = 4'b1101;

  localparam logic [3:0] M_LOAD  = 4'b0000;
  localparam logic [3:0] M_STOR  = 4'b0100;
  localparam logic [3:0] M_JCOND = 4'b1100;

  localparam logic [7:0] OP_NOP = 8'h02;

  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b01;
  localparam logic [1:0] ST_MEM0  = 2'b10;

  typedef enum logic [1:0] {
    EMPTY = ST_EMPTY,
    ONE   = ST_ONE,
    MEM0  = ST_MEM0
  } state_e;

  function automatic logic is_r_sub(input logic [3:0] s);
    return s inside {R_AND, R_OR, R_XOR, R_ADDCU,
                     R_ADD, R_ADDU, R_ADDC, R_SUB,
                     R_CMP, R_MOV, R_NOT};
  endfunction

  function automatic logic is_sext(input logic [3:0] c);
    return c inside {CL_ADDI, CL_SUBI, CL_CMPI, CL_ADDCI};
  endfunction

  function automatic logic is_zext(input logic [3:0] c);
    return c inside {CL_ADDUI, CL_SUBCI, CL_CMPUI, CL_MOVI};
  endfunction

  function automatic logic is_sh_reg(input logic [3:0] s);
    return s inside {SH_LSH, SH_RSH, SH_ALSH, SH_ARSH};
  endfunction

  function automatic logic is_sh_imm(input logic [3:0] s);
    return s inside {SH_LSHI, SH_RSHI};
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and datapath-side handshakes of the decode stage.
// slave = decode stage, master = surrounding pipeline.
interface decode_stage_if #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4,
  parameter int INST_W = 18
);
  logic              in_valid;
  logic              in_ready;
  logic [INST_W-1:0] inst;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        op;
  logic [DATA_W-1:0] imm;
  logic              sel_imm;
  logic              sel_result;
  logic              mem_we;
  logic              reg_we;
  logic              is_branch;
  logic [3:0]        br_cond;
  logic [REG_AW-1:0] rd_a;
  logic [REG_AW-1:0] rd_b;
  logic [REG_AW-1:0] ld_reg;

  modport slave (
    input  in_valid, inst, out_ready,
    output in_ready, out_valid, op, imm,
    output sel_imm, sel_result, mem_we,
    output reg_we, is_branch, br_cond,
    output rd_a, rd_b, ld_reg
  );

  modport master (
    output in_valid, inst, out_ready,
    input  in_ready, out_valid, op, imm,
    input  sel_imm, sel_result, mem_we,
    input  reg_we, is_branch, br_cond,
    input  rd_a, rd_b, ld_reg
  );
endinterface

// File: rtl/imm_extend.sv
// Combinational immediate extender: builds the DATA_W
// immediate from instruction class, sub-op and low byte.
module imm_extend
  import isa_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [3:0]        cls,
  input  logic [3:0]        sub,
  input  logic [7:0]        lo,
  output logic [DATA_W-1:0] imm
);

  always_comb begin
    imm = '0;
    unique case (1'b1)
      is_sext(cls): imm = DATA_W'($signed(lo));
      is_zext(cls): imm = DATA_W'(lo);
      cls == CL_LUI: imm[DATA_W-1 -: 8] = lo;
      cls == CL_SH && is_sh_imm(sub):
        imm = DATA_W'(lo[3:0]);
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Registered handshaked decode stage; LOAD/STOR issue two beats.
// Optional DECODE_LI_EN: inst[17:16]=11 is a 16-bit load-immediate.
module decode_stage
  import isa_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4,
  parameter int INST_W = 18
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  output logic           busy,
  decode_stage_if.slave  io
);

  typedef struct packed {
    logic [7:0]        op;
    logic [DATA_W-1:0] imm;
    logic              sel_imm;
    logic              sel_result;
    logic              mem_we;
    logic              reg_we;
    logic              is_branch;
    logic [3:0]        br_cond;
    logic [REG_AW-1:0] rd_a;
    logic [REG_AW-1:0] rd_b;
    logic [REG_AW-1:0] ld_reg;
  } beat_t;

  state_e            state;
  beat_t             out_q, shadow_q;
  beat_t             nop, beat0, beat1;
  logic              two_beat, accept;
  logic [3:0]        cls, sub;
  logic [REG_AW-1:0] ra, rb;
  logic [DATA_W-1:0] ext_imm;
  logic              base, li;
  logic              r_ok, i_ok, shr, shi;
  logic              ld, st, jc;

  assign cls  = io.inst[15:12];
  assign sub  = io.inst[7:4];
  assign ra   = REG_AW'(io.inst[11:8]);
  assign rb   = REG_AW'(io.inst[3:0]);
  assign base = io.inst[17:16] == 2'b00;

`ifdef DECODE_LI_EN
  assign li = io.inst[17:16] == 2'b11;
`else
  assign li = 1'b0;
`endif

  assign r_ok = base && cls == CL_R && is_r_sub(sub);
  assign i_ok = base && (is_sext(cls) || is_zext(cls)
                         || cls == CL_LUI);
  assign shr  = base && cls == CL_SH && is_sh_reg(sub);
  assign shi  = base && cls == CL_SH && is_sh_imm(sub);
  assign ld   = base && cls == CL_MEM && sub == M_LOAD;
  assign st   = base && cls == CL_MEM && sub == M_STOR;
  assign jc   = base && cls == CL_MEM && sub == M_JCOND;

  imm_extend #(.DATA_W(DATA_W)) u_imm (
    .cls (cls),
    .sub (sub),
    .lo  (io.inst[7:0]),
    .imm (ext_imm)
  );

  always_comb begin
    nop        = '0;
    nop.op     = OP_NOP;
    nop.rd_a   = ra;
    nop.rd_b   = ra;
    nop.ld_reg = ra;
    beat0      = nop;
    beat1      = nop;
    two_beat   = 1'b0;
    unique case (1'b1)
      r_ok: begin
        beat0.op     = {CL_R, sub};
        beat0.rd_a   = (sub == R_MOV) ? rb : ra;
        beat0.rd_b   = rb;
        beat0.reg_we = sub != R_CMP;
      end
      i_ok: begin
        beat0.op      = {cls, sub};
        beat0.imm     = ext_imm;
        beat0.sel_imm = 1'b1;
        beat0.rd_b    = rb;
        beat0.reg_we  = !(cls == CL_CMPI || cls == CL_CMPUI);
      end
      shr: begin
        beat0.op     = {CL_SH, sub};
        beat0.rd_b   = rb;
        beat0.reg_we = 1'b1;
      end
      shi: begin
        beat0.op      = {CL_SH, sub};
        beat0.imm     = ext_imm;
        beat0.sel_imm = 1'b1;
        beat0.rd_b    = rb;
        beat0.reg_we  = 1'b1;
      end
      ld: begin
        beat0.rd_a       = rb;
        beat0.rd_b       = rb;
        beat1            = beat0;
        beat1.sel_result = 1'b1;
        beat1.reg_we     = 1'b1;
        two_beat         = 1'b1;
      end
      st: begin
        beat0.mem_we = 1'b1;
        beat0.rd_b   = rb;
        two_beat     = 1'b1;
      end
      jc: begin
        beat0.is_branch = 1'b1;
        beat0.br_cond   = io.inst[3:0];
        beat0.rd_b      = rb;
      end
      li: begin
        beat0.op      = {4'b1111, sub};
        beat0.imm     = DATA_W'(io.inst[15:0]);
        beat0.sel_imm = 1'b1;
        beat0.reg_we  = 1'b1;
        beat0.rd_b    = rb;
      end
      default: beat0 = nop;
    endcase
  end

  assign io.in_ready = !flush &&
    (state == EMPTY || (state == ONE && io.out_ready));
  assign accept = io.in_valid && io.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      out_q    <= '0;
      shadow_q <= '0;
    end else if (flush) begin
      state <= EMPTY;
    end else if (accept) begin
      out_q    <= beat0;
      shadow_q <= beat1;
      state    <= two_beat ? MEM0 : ONE;
    end else if (io.out_ready) begin
      if (state == MEM0) begin
        out_q <= shadow_q;
        state <= ONE;
      end else if (state == ONE) begin
        state <= EMPTY;
      end
    end
  end

  assign busy          = state == MEM0;
  assign io.out_valid  = state != EMPTY;
  assign io.op         = out_q.op;
  assign io.imm        = out_q.imm;
  assign io.sel_imm    = out_q.sel_imm;
  assign io.sel_result = out_q.sel_result;
  assign io.mem_we     = out_q.mem_we;
  assign io.reg_we     = out_q.reg_we;
  assign io.is_branch  = out_q.is_branch;
  assign io.br_cond    = out_q.br_cond;
  assign io.rd_a       = out_q.rd_a;
  assign io.rd_b       = out_q.rd_b;
  assign io.ld_reg     = out_q.ld_reg;

endmodule
